// File: rtl/alu_pkg.sv
// Shared definitions for the six-bit ALU arbiter: opcode and FSM encodings
// plus the default operand width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 6;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_XNOR = 2'b10,
        OP_AND  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/sixbit_alu_core.sv
// Purely combinational ALU: ADD/SUB with carry/borrow flag, bitwise XNOR/AND.
module sixbit_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             flag
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y    = '0;
        flag = 1'b0;
        case (op)
            OP_ADD: begin
                y    = sum[WIDTH-1:0];
                flag = sum[WIDTH];
            end
            OP_SUB: begin
                y    = a - b;
                flag = (a < b);
            end
            OP_XNOR: y = ~(a ^ b);
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/sixbit_alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU: accept one operation,
// compute it in one cycle, hold the result until the consumer takes it.
module sixbit_alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             res_id
);

    state_e           state, state_nxt;
    logic             last_gnt;
    logic             gnt_id;
    logic             accept;

    logic [WIDTH-1:0] a_p0, b_p0;
    logic [1:0]       op_p0;
    logic             id_p0;

    logic [WIDTH-1:0] alu_y;
    logic             alu_flag;

    // Grant decision is combinational on valids only; res_ready never reaches it.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    gnt_id     = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: operands captured at acceptance, isolated from later input changes
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= gnt_id ? req1_a  : req0_a;
            b_p0  <= gnt_id ? req1_b  : req0_b;
            op_p0 <= gnt_id ? req1_op : req0_op;
            id_p0 <= gnt_id;
        end
    end

    sixbit_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (a_p0),
        .b    (b_p0),
        .op   (op_p0),
        .y    (alu_y),
        .flag (alu_flag)
    );

    // Stage p1: result registers, written only on the single EXEC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            res_data <= '0;
            res_flag <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                last_gnt <= gnt_id;
            if (state == ST_EXEC) begin
                res_data <= alu_y;
                res_flag <= alu_flag;
                res_id   <= id_p0;
            end
        end
    end

    assign res_valid = (state == ST_DONE);

endmodule

// File: tb/tb_sixbit_alu_arbiter.sv
// Directed-vector bench for sixbit_alu_arbiter with hand-computed expectations.
module tb_sixbit_alu_arbiter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [1:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [1:0]   req1_op;
    logic         res_valid, res_ready;
    logic [W-1:0] res_data;
    logic         res_flag, res_id;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sixbit_alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flag   (res_flag),
        .res_id     (res_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        reset = 1'b1;
        res_ready = 1'b0;
        set0(1'b0, 2'b00, '0, '0);
        set1(1'b0, 2'b00, '0, '0);
        tick();
        tick();

        // Reset state, and no ready while reset is high
        req0_valid = 1'b1;
        settle();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_flag", res_flag, 0);
        chk("rst_id", res_id, 0);

        // Single ADD 40+30 -> 6, carry 1
        reset = 1'b0;
        set0(1'b1, 2'b00, 6'd40, 6'd30);
        settle();
        chk("add_ready0_T", req0_ready, 1);
        chk("add_ready1_T", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("add_ready0_T1", req0_ready, 0);
        chk("add_valid_T1", res_valid, 0);
        tick();
        chk("add_valid_T2", res_valid, 1);
        chk("add_data", res_data, 6'd6);
        chk("add_flag", res_flag, 1);
        chk("add_id", res_id, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("add_consumed", res_valid, 0);

        // Contended round robin, res_ready held high throughout
        do_reset();
        set0(1'b1, 2'b01, 6'd5, 6'd9);
        set1(1'b1, 2'b10, 6'b101010, 6'b100011);
        res_ready = 1'b1;
        settle();
        chk("rr_g1_req0", req0_ready, 1);
        chk("rr_g1_req1", req1_ready, 0);
        tick();
        settle();
        chk("rr_exec_req1", req1_ready, 0);
        tick();
        chk("rr_sub_valid", res_valid, 1);
        chk("rr_sub_data", res_data, 6'd60);
        chk("rr_sub_flag", res_flag, 1);
        chk("rr_sub_id", res_id, 0);
        tick();
        chk("rr_g2_req1", req1_ready, 1);
        chk("rr_g2_req0", req0_ready, 0);
        tick();
        tick();
        chk("rr_xnor_data", res_data, 6'b110110);
        chk("rr_xnor_flag", res_flag, 0);
        chk("rr_xnor_id", res_id, 1);
        tick();
        chk("rr_g3_req0", req0_ready, 1);
        chk("rr_g3_req1", req1_ready, 0);

        // Back-pressure: result held for 10 cycles, no new grant
        do_reset();
        set0(1'b1, 2'b00, 6'd1, 6'd2);
        settle();
        chk("bp_accept", req0_ready, 1);
        tick();
        set1(1'b1, 2'b11, 6'h0F, 6'h0F);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 6'd3);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        settle();
        chk("bp_rr_no_comb", {req0_ready, req1_ready}, 2'b00);
        tick();
        res_ready = 1'b0;
        settle();
        chk("bp_released", res_valid, 0);
        chk("bp_next_grant1", req1_ready, 1);
        chk("bp_next_grant0", req0_ready, 0);

        // Reset during EXEC discards the operation and restores req0 priority
        do_reset();
        set0(1'b1, 2'b00, 6'd7, 6'd7);
        settle();
        chk("rx_accept", req0_ready, 1);
        tick();
        reset = 1'b1;
        req0_valid = 1'b0;
        tick();
        chk("rx_valid", res_valid, 0);
        reset = 1'b0;
        tick();
        chk("rx_valid_idle", res_valid, 0);
        chk("rx_data", res_data, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        settle();
        chk("rx_grant0", req0_ready, 1);
        chk("rx_grant1", req1_ready, 0);

        // Reset during DONE drops the unconsumed result
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("rd_valid_pre", res_valid, 1);
        reset = 1'b1;
        tick();
        chk("rd_valid", res_valid, 0);
        chk("rd_data", res_data, 0);
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        settle();
        chk("rd_grant0", req0_ready, 1);
        chk("rd_grant1", req1_ready, 0);

        // Lone req1 AND, operands scrambled right after acceptance
        do_reset();
        set1(1'b1, 2'b11, 6'h3F, 6'h15);
        res_ready = 1'b1;
        settle();
        chk("and_accept", req1_ready, 1);
        tick();
        set1(1'b0, 2'b00, 6'h00, 6'h2A);
        tick();
        chk("and_valid", res_valid, 1);
        chk("and_data", res_data, 6'h15);
        chk("and_flag", res_flag, 0);
        chk("and_id", res_id, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
